// File: rtl/counter_pkg.sv
// Shared constants and sizing helper for the parametrised event/timebase counter.
package counter_pkg;

  localparam bit CNT_MODE_WRAP = 1'b0;
  localparam bit CNT_MODE_SAT  = 1'b1;
  localparam bit CNT_DIR_UP    = 1'b1;
  localparam bit CNT_DIR_DOWN  = 1'b0;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE and emits a one-cycle step strobe.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic unused_ok;
      assign unused_ok = clk ^ reset;
      assign tick      = en && !clr;
    end else begin : g_div
      localparam int PW = clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase;

      always_ff @(posedge clk) begin
        if (reset || clr) begin
          phase <= '0;
        end else if (en) begin
          phase <= (phase == LAST) ? '0 : phase + 1'b1;
        end
      end

      assign tick = en && !clr && (phase == LAST);
    end
  endgenerate

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with load, modulus, wrap-or-saturate bounds and input prescaler.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter bit SATURATE = CNT_MODE_WRAP,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             tick
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .tick  (tick)
  );

  // Bounds are tested before the +1/-1, so no value above MAX is ever formed.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= (load_val > MAX) ? MAX : load_val;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (tick) begin
        if (up_dn == CNT_DIR_UP) begin
          if (count == MAX) begin
            wrap <= 1'b1;
            if (SATURATE == CNT_MODE_WRAP) count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end else begin
          if (count == '0) begin
            wrap <= 1'b1;
            if (SATURATE == CNT_MODE_WRAP) count <= MAX;
          end else begin
            count <= count - 1'b1;
          end
        end
      end
    end
  end

  assign tc = up_dn ? (count == MAX) : (count == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Three counter configurations driven by shared stimulus and checked against a behavioural model.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] count_a, count_b, count_c;
  logic       tc_a, tc_b, tc_c, wrap_a, wrap_b, wrap_c, tick_a, tick_b, tick_c;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0] count;
    logic       wrap;
    logic       tc;
    logic       tick;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  // a: mod-10 wrap /3 ; b: mod-10 saturate ; c: full 4-bit wrap
  int MV[3]  = '{9, 9, 15};
  int PS[3]  = '{3, 1, 1};
  int SAT[3] = '{0, 1, 0};

  int m_cnt[3] = '{0, 0, 0};
  int m_ph[3]  = '{0, 0, 0};
  int m_wr[3]  = '{0, 0, 0};

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .PRESCALE(3)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count_a), .tc(tc_a), .wrap(wrap_a), .tick(tick_a));

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .PRESCALE(1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count_b), .tc(tc_b), .wrap(wrap_b), .tick(tick_b));

  param_updown_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0), .PRESCALE(1)) dut_c (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count_c), .tc(tc_c), .wrap(wrap_c), .tick(tick_c));

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, expv);
    end
  endtask

  // Drive one cycle, record what each counter should show now, then advance the model.
  task automatic cyc(input bit r, input bit e, input bit u, input bit l, input int lv);
    @(negedge clk);
    reset = r; en = e; up_dn = u; load = l; load_val = 4'(lv);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_t x;
      bit   tk;
      tk      = e && !l && (m_ph[i] == PS[i] - 1);
      x.count = 4'(m_cnt[i]);
      x.wrap  = (m_wr[i] != 0);
      x.tc    = u ? (m_cnt[i] == MV[i]) : (m_cnt[i] == 0);
      x.tick  = tk;
      if (i == 0) q0.push_back(x);
      else if (i == 1) q1.push_back(x);
      else q2.push_back(x);

      if (r) begin
        m_cnt[i] = 0; m_ph[i] = 0; m_wr[i] = 0;
      end else if (l) begin
        m_cnt[i] = (lv > MV[i]) ? MV[i] : lv;
        m_ph[i]  = 0;
        m_wr[i]  = 0;
      end else begin
        m_wr[i] = 0;
        if (e) m_ph[i] = (m_ph[i] + 1) % PS[i];
        if (tk) begin
          if (u) begin
            if (m_cnt[i] == MV[i]) begin
              m_wr[i] = 1;
              if (SAT[i] == 0) m_cnt[i] = 0;
            end else m_cnt[i] = m_cnt[i] + 1;
          end else begin
            if (m_cnt[i] == 0) begin
              m_wr[i] = 1;
              if (SAT[i] == 0) m_cnt[i] = MV[i];
            end else m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end
    end
  endtask

  task automatic cmp(input string tag, input exp_t x, input logic [3:0] c,
                     input logic w, input logic t, input logic k);
    chk({tag, "_count"}, int'(c), int'(x.count));
    chk({tag, "_wrap"},  int'(w), int'(x.wrap));
    chk({tag, "_tc"},    int'(t), int'(x.tc));
    chk({tag, "_tick"},  int'(k), int'(x.tick));
  endtask

  // Monitor: every cycle the counters present outputs, pop one expectation per instance.
  initial begin
    wait (q0.size() > 0);
    #1;
    forever begin
      if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        cmp("a", q0.pop_front(), count_a, wrap_a, tc_a, tick_a);
        cmp("b", q1.pop_front(), count_b, wrap_b, tc_b, tick_b);
        cmp("c", q2.pop_front(), count_c, wrap_c, tc_c, tick_c);
      end
      @(negedge clk);
      #2;
    end
  end

  initial begin
    repeat (2) cyc(1, 0, 1, 0, 0);
    repeat (40) cyc(0, 1, 1, 0, 0);          // up through both bounds
    repeat (4) cyc(0, 1, 0, 0, 0);           // turn around
    cyc(0, 1, 1, 1, 13);                     // over-range load with tick pending
    repeat (4) cyc(0, 1, 1, 0, 0);
    repeat (5) cyc(0, 0, 1, 0, 0);           // frozen mid-period
    repeat (6) cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (10) cyc(0, 1, 0, 0, 0);          // down past zero
    cyc(0, 1, 1, 1, 7);
    cyc(0, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 5);                      // reset beats load
    repeat (8) cyc(0, 1, 1, 0, 0);
    for (int n = 0; n < 600; n++) begin
      bit r, e, u, l;
      r = ($urandom_range(99) < 2);
      l = ($urandom_range(99) < 6);
      e = ($urandom_range(99) < 80);
      u = ($urandom_range(99) < 55);
      cyc(r, e, u, l, int'($urandom_range(15)));
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
